hazard_tracker: RTL and testbench

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_cmp.sv | 31 +++
 rtl/hazard_tracker.sv | 109 ++++++++++
 tb/tb_hazard_tracker.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding encodings and the "no use" T_use constant
package hazard_pkg;
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_M    = 2'b01,
        FWD_W    = 2'b10
    } fwd_e;
    // All-ones "no use" marker; callers slice it to their T_use width
    localparam logic [31:0] T_NONE = '1;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: per-source stall/forward compare against the E, M and W slots
// Ports: i_src/i_tuse source register and its T_use; i_e_*/i_m_*/i_w_* slot
//        fields; o_stall data-hazard stall; o_fwd bypass select (M over W).
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input  logic [AW-1:0] i_src,
    input  logic [TW-1:0] i_tuse,
    input  logic [AW-1:0] i_e_waddr,
    input  logic          i_e_we,
    input  logic [TW-1:0] i_e_tnew,
    input  logic [AW-1:0] i_m_waddr,
    input  logic          i_m_we,
    input  logic [TW-1:0] i_m_tnew,
    input  logic [AW-1:0] i_w_waddr,
    input  logic          i_w_we,
    output logic          o_stall,
    output logic [1:0]    o_fwd
);
    logic w_use, w_e_hit, w_m_hit, w_w_hit;
    // $0 never produces a hazard or a bypass
    assign w_use   = i_tuse != T_NONE[TW-1:0];
    assign w_e_hit = (i_src != '0) && i_e_we && (i_e_waddr == i_src);
    assign w_m_hit = (i_src != '0) && i_m_we && (i_m_waddr == i_src);
    assign w_w_hit = (i_src != '0) && i_w_we && (i_w_waddr == i_src);
    assign o_stall = w_use && ((w_e_hit && i_e_tnew > i_tuse) || (w_m_hit && i_m_tnew > i_tuse));
    assign o_fwd   = (w_m_hit && i_m_tnew == '0) ? FWD_M : w_w_hit ? FWD_W : FWD_NONE;
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: pipeline hazard tracker producing stall and bypass selects
// Ports: clk, reset (sync, active-high); D_* decode-stage sources, T_use,
//        destination/T_new and mult/div controls; stall; fwd_{rs,rt}_{D,E}.
// Macro HAZARD_MD_STALL_EN enables the mult/div busy counter and MD stall.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] D_rs,
    input  logic [AW-1:0] D_rt,
    input  logic [TW-1:0] D_tuse_rs,
    input  logic [TW-1:0] D_tuse_rt,
    input  logic [AW-1:0] D_waddr,
    input  logic          D_we,
    input  logic [TW-1:0] D_tnew,
    input  logic          D_md_start,
    input  logic          D_md_div,
    input  logic          D_md_use,
    output logic          stall,
    output logic [1:0]    fwd_rs_D,
    output logic [1:0]    fwd_rt_D,
    output logic [1:0]    fwd_rs_E,
    output logic [1:0]    fwd_rt_E
);
    localparam int CW = $clog2((MUL_CYC > DIV_CYC ? MUL_CYC : DIV_CYC) + 1);
    logic [AW-1:0] r_e_rs, r_e_rt, r_e_waddr, r_m_waddr, r_w_waddr;
    logic          r_e_we, r_m_we, r_w_we, r_e_md_start, r_e_md_div;
    logic [TW-1:0] r_e_tnew, r_m_tnew;
    logic          w_st_rs_d, w_st_rt_d, w_st_rs_e, w_st_rt_e, w_md_stall;
    hazard_cmp #(.AW(AW), .TW(TW)) u_rs_d (
        .i_src(D_rs), .i_tuse(D_tuse_rs),
        .i_e_waddr(r_e_waddr), .i_e_we(r_e_we), .i_e_tnew(r_e_tnew),
        .i_m_waddr(r_m_waddr), .i_m_we(r_m_we), .i_m_tnew(r_m_tnew),
        .i_w_waddr(r_w_waddr), .i_w_we(r_w_we),
        .o_stall(w_st_rs_d), .o_fwd(fwd_rs_D)
    );
    hazard_cmp #(.AW(AW), .TW(TW)) u_rt_d (
        .i_src(D_rt), .i_tuse(D_tuse_rt),
        .i_e_waddr(r_e_waddr), .i_e_we(r_e_we), .i_e_tnew(r_e_tnew),
        .i_m_waddr(r_m_waddr), .i_m_we(r_m_we), .i_m_tnew(r_m_tnew),
        .i_w_waddr(r_w_waddr), .i_w_we(r_w_we),
        .o_stall(w_st_rt_d), .o_fwd(fwd_rt_D)
    );
    // E-stage sources only need bypass selects; "no use" keeps their stall at 0
    hazard_cmp #(.AW(AW), .TW(TW)) u_rs_e (
        .i_src(r_e_rs), .i_tuse(T_NONE[TW-1:0]),
        .i_e_waddr('0), .i_e_we(1'b0), .i_e_tnew('0),
        .i_m_waddr(r_m_waddr), .i_m_we(r_m_we), .i_m_tnew(r_m_tnew),
        .i_w_waddr(r_w_waddr), .i_w_we(r_w_we),
        .o_stall(w_st_rs_e), .o_fwd(fwd_rs_E)
    );
    hazard_cmp #(.AW(AW), .TW(TW)) u_rt_e (
        .i_src(r_e_rt), .i_tuse(T_NONE[TW-1:0]),
        .i_e_waddr('0), .i_e_we(1'b0), .i_e_tnew('0),
        .i_m_waddr(r_m_waddr), .i_m_we(r_m_we), .i_m_tnew(r_m_tnew),
        .i_w_waddr(r_w_waddr), .i_w_we(r_w_we),
        .o_stall(w_st_rt_e), .o_fwd(fwd_rt_E)
    );
    assign stall = w_st_rs_d | w_st_rt_d | w_st_rs_e | w_st_rt_e | w_md_stall;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_rs       <= '0;
            r_e_rt       <= '0;
            r_e_waddr    <= '0;
            r_e_we       <= 1'b0;
            r_e_tnew     <= '0;
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
            r_m_waddr    <= '0;
            r_m_we       <= 1'b0;
            r_m_tnew     <= '0;
            r_w_waddr    <= '0;
            r_w_we       <= 1'b0;
        end else begin
            r_e_rs       <= stall ? '0 : D_rs;
            r_e_rt       <= stall ? '0 : D_rt;
            r_e_waddr    <= stall ? '0 : D_waddr;
            r_e_we       <= stall ? 1'b0 : D_we;
            r_e_tnew     <= stall ? '0 : D_tnew;
            r_e_md_start <= stall ? 1'b0 : D_md_start;
            r_e_md_div   <= stall ? 1'b0 : D_md_div;
            r_m_waddr    <= r_e_waddr;
            r_m_we       <= r_e_we;
            r_m_tnew     <= (r_e_tnew == '0) ? '0 : r_e_tnew - 1'b1;
            r_w_waddr    <= r_m_waddr;
            r_w_we       <= r_m_we;
        end
    end
`ifdef HAZARD_MD_STALL_EN
    logic [CW-1:0] r_md_cnt;
    always_ff @(posedge clk) begin
        if (reset) r_md_cnt <= '0;
        else if (r_e_md_start) r_md_cnt <= r_e_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
        else if (r_md_cnt != '0) r_md_cnt <= r_md_cnt - 1'b1;
    end
    assign w_md_stall = D_md_use && (r_e_md_start || r_md_cnt != '0);
`else
    logic w_unused;
    assign w_md_stall = 1'b0;
    assign w_unused   = ^{D_md_start, D_md_div, D_md_use, r_e_md_start, r_e_md_div,
                          CW'(MUL_CYC), CW'(DIV_CYC)};
`endif
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed self-checking bench for hazard_tracker
module tb_hazard_tracker;
    localparam int AW = 5, TW = 2, MUL_CYC = 5, DIV_CYC = 10;
    localparam logic [1:0] NU = 2'b11;
`ifdef HAZARD_MD_STALL_EN
    localparam int MD_EN = 1;
`else
    localparam int MD_EN = 0;
`endif
    logic          clk = 1'b0, reset = 1'b1;
    logic [AW-1:0] D_rs, D_rt, D_waddr;
    logic [TW-1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic          D_we, D_md_start, D_md_div, D_md_use;
    logic          stall;
    logic [1:0]    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    int            tests = 0, fails = 0, n;

    hazard_tracker #(.AW(AW), .TW(TW), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_waddr(D_waddr), .D_we(D_we), .D_tnew(D_tnew),
        .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
        .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int rs, input int rt, input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input int wa, input logic we, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu);
        D_rs = AW'(rs); D_rt = AW'(rt); D_tuse_rs = tu_rs; D_tuse_rt = tu_rt;
        D_waddr = AW'(wa); D_we = we; D_tnew = tn;
        D_md_start = ms; D_md_div = md; D_md_use = mu;
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"}, int'(stall), 0);
        chk({tag, "_fwd_rs_D"}, int'(fwd_rs_D), 0);
        chk({tag, "_fwd_rt_D"}, int'(fwd_rt_D), 0);
        chk({tag, "_fwd_rs_E"}, int'(fwd_rs_E), 0);
        chk({tag, "_fwd_rt_E"}, int'(fwd_rt_E), 0);
    endtask

    task automatic count_stall(output int cnt);
        cnt = 0;
        while (stall && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        set_d(0, 0, NU, NU, 0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk_quiet("reset");
        // load-use: lw $8 (tnew=2) then add reads $8 (tuse=1)
        set_d(29, 0, NU, NU, 8, 1, 2, 0, 0, 0);
        step();
        set_d(8, 9, 1, 1, 11, 1, 1, 0, 0, 0);
        chk("lu_stall_c0", int'(stall), 1);
        step();
        chk("lu_stall_c1", int'(stall), 0);
        step();
        set_d(0, 0, NU, NU, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_rs_E", int'(fwd_rs_E), 2);
        chk("lu_fwd_rt_E", int'(fwd_rt_E), 0);
        // ALU back-to-back: add $9 (tnew=1) then sub reads $9 as rt
        set_d(1, 2, 1, 1, 9, 1, 1, 0, 0, 0);
        step();
        set_d(3, 9, 1, 1, 12, 1, 1, 0, 0, 0);
        chk("alu_stall", int'(stall), 0);
        step();
        chk("alu_fwd_rt_E", int'(fwd_rt_E), 1);
        chk("alu_fwd_rs_E", int'(fwd_rs_E), 0);
        // branch after ALU: add $10 (tnew=1) then beq reads $10 (tuse=0)
        set_d(4, 5, 1, 1, 10, 1, 1, 0, 0, 0);
        chk("br_pre_stall", int'(stall), 0);
        step();
        set_d(10, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_stall_c0", int'(stall), 1);
        step();
        chk("br_stall_c1", int'(stall), 0);
        chk("br_fwd_rs_D", int'(fwd_rs_D), 1);
        chk("br_fwd_rt_D", int'(fwd_rt_D), 0);
        step();
        // $0 writer (tnew=2) then $0 reader
        set_d(0, 0, NU, NU, 0, 1, 2, 0, 0, 0);
        step();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("z_stall", int'(stall), 0);
        chk("z_fwd_rs_D", int'(fwd_rs_D), 0);
        chk("z_fwd_rt_D", int'(fwd_rt_D), 0);
        step();
        chk_quiet("z_e");
        step();
        chk_quiet("z_w");
        // div then mfhi
        set_d(0, 0, NU, NU, 0, 0, 0, 1, 1, 0);
        step();
        set_d(0, 0, NU, NU, 13, 1, 1, 0, 0, 1);
        count_stall(n);
        chk("div_stall_cycles", n, MD_EN ? DIV_CYC + 1 : 0);
        step();
        // mult then mfhi
        set_d(0, 0, NU, NU, 0, 0, 0, 1, 0, 0);
        step();
        set_d(0, 0, NU, NU, 13, 1, 1, 0, 0, 1);
        count_stall(n);
        chk("mul_stall_cycles", n, MD_EN ? MUL_CYC + 1 : 0);
        step();
        // reset two cycles after mult enters E
        set_d(0, 0, NU, NU, 0, 0, 0, 1, 0, 0);
        step();
        set_d(0, 0, NU, NU, 13, 1, 1, 0, 0, 1);
        chk("rm_busy_stall", int'(stall), MD_EN);
        step();
        step();
        chk("rm_busy_stall2", int'(stall), MD_EN);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_quiet("rm_after");
        step();
        chk("rm_stall_next", int'(stall), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
